gray_rx_decoder: RTL and testbench

GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

---
 rtl/gray_pkg.sv | 6 +
 rtl/gray2bin.sv | 14 +
 rtl/gray_rx_decoder.sv | 86 ++++++++
 tb/tb_gray_rx_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared state encoding and default width for the Gray receive decoder
// Contents: state_t (IDLE/LOCK/TRACK/ERROR) and CBITS_DEF, the default code width.
package gray_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK = 2'd1, TRACK = 2'd2, ERROR = 2'd3} state_t;
  localparam int CBITS_DEF = 17;
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decode, each bit is the XOR of all Gray bits at or above it
// Ports: g (Gray input, CBITS), b (binary output, CBITS).
module gray2bin
  import gray_pkg::*;
#(
  parameter int CBITS = CBITS_DEF
) (
  input  logic [CBITS-1:0] g,
  output logic [CBITS-1:0] b
);
  for (genvar i = 0; i < CBITS; i++) begin : g_bit
    assign b[i] = ^g[CBITS-1:i];
  end
endmodule

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: registers, decodes and step-checks a Gray count stream from an upstream counter
// Ports: clk, rst (async, active-high); gray_in/in_valid sample input; err_clr releases ERROR to LOCK;
//        bin_out/bin_valid decoded result; wrap and step_err pulse with bin_valid; err_cnt saturating
//        illegal-step count; state current FSM encoding.
// Define GRAY_RX_SYNC_EN to add a 2-flop input synchronizer (latency 4 instead of 2).
// err_clr acts on the cycle a sample sits in stage 1, so it "coincides" with that sample's decode.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int CBITS = CBITS_DEF,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             in_valid,
  input  logic             err_clr,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_valid,
  output logic             wrap,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);
  logic [CBITS-1:0] g_pre, s1_g, dec;
  logic             v_pre, s1_v, legal, wrap_n, err_n;
  state_t           st, st_n;
`ifdef GRAY_RX_SYNC_EN
  logic [CBITS-1:0] sy_g0, sy_g1;
  logic             sy_v0, sy_v1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sy_g0 <= '0;
      sy_g1 <= '0;
      sy_v0 <= 1'b0;
      sy_v1 <= 1'b0;
    end else begin
      sy_g0 <= gray_in;
      sy_g1 <= sy_g0;
      sy_v0 <= in_valid;
      sy_v1 <= sy_v0;
    end
  assign g_pre = sy_g1;
  assign v_pre = sy_v1;
`else
  assign g_pre = gray_in;
  assign v_pre = in_valid;
`endif
  gray2bin #(.CBITS(CBITS)) u_g2b (.g(s1_g), .b(dec));
  // bin_out always holds the last decoded sample, so it doubles as the reference value prev
  assign legal = dec == bin_out || dec == bin_out + CBITS'(1);
  always_comb begin
    st_n   = st;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (st == ERROR && err_clr) st_n = LOCK;
    else if (s1_v && st == IDLE) st_n = LOCK;
    else if (s1_v && st != ERROR) begin
      st_n   = legal ? TRACK : ERROR;
      err_n  = !legal;
      wrap_n = bin_out == '1 && dec == '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_g      <= '0;
      s1_v      <= 1'b0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      s1_g      <= g_pre;
      s1_v      <= v_pre;
      bin_out   <= s1_v ? dec : bin_out;
      bin_valid <= s1_v;
      wrap      <= wrap_n;
      step_err  <= err_n;
      if (err_n && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  assign state = st;
endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: table-driven scoreboard bench for gray_rx_decoder plus wrap, saturation and reset sequences
module tb_gray_rx_decoder;
  import gray_pkg::*;
  localparam int CB = 17;
`ifdef GRAY_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    logic [CB-1:0] b;
    logic          v;
    logic          c;
    logic          w;
    logic          e;
    logic [1:0]    st;
    logic [7:0]    cnt;
  } vec_t;
  logic          clk, rst;
  logic [CB-1:0] gray_in, bin_out;
  logic          in_valid, err_clr, bin_valid, wrap, step_err;
  logic [7:0]    err_cnt;
  logic [1:0]    state;
  logic [3:0]    g4, b4, wbin;
  logic          v4, c4, bv4, w4, e4;
  logic [7:0]    ec4;
  logic [1:0]    st4;
  logic [LAT-2:0] cpipe;
  vec_t          sb[$];
  vec_t          tbl[$];
  vec_t          mx;
  int            n_cmp, n_bad, wcnt, ecnt4;
  gray_rx_decoder dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .wrap(wrap), .step_err(step_err),
    .err_cnt(err_cnt), .state(state)
  );
  gray_rx_decoder #(.CBITS(4), .ERR_W(8)) dut4 (
    .clk(clk), .rst(rst), .gray_in(g4), .in_valid(v4), .err_clr(c4),
    .bin_out(b4), .bin_valid(bv4), .wrap(w4), .step_err(e4),
    .err_cnt(ec4), .state(st4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(int b, bit v, bit c, bit w, bit e, int st, int cnt);
    vec_t r;
    r.b = CB'(b);
    r.v = v;
    r.c = c;
    r.w = w;
    r.e = e;
    r.st = 2'(st);
    r.cnt = 8'(cnt);
    return r;
  endfunction
  // err_clr is delayed LAT-1 cycles so it lands while its sample sits in stage 1
  task automatic send(input vec_t x);
    @(posedge clk);
    #1;
    gray_in  = x.b ^ (x.b >> 1);
    in_valid = x.v;
    err_clr  = cpipe[LAT-2];
    cpipe    = (cpipe << 1) | (LAT-1)'(x.c);
    if (x.v) sb.push_back(x);
  endtask
  task automatic idle(input int n);
    repeat (n) send(mk(0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    err_clr = 1'b0;
    cpipe = '0;
    v4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  always @(negedge clk)
    if (!rst && bin_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_bin_valid: got bin_out=%0d, expected no output (t=%0t)", bin_out, $time);
      end else begin
        mx = sb.pop_front();
        chk("bin_out", bin_out, mx.b);
        chk("wrap", wrap, mx.w);
        chk("step_err", step_err, mx.e);
        chk("state", state, mx.st);
        chk("err_cnt", err_cnt, mx.cnt);
      end
    end
  always @(negedge clk)
    if (!rst && !bin_valid && (wrap || step_err)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_without_valid: got wrap=%0b step_err=%0b, expected 0 (t=%0t)", wrap, step_err, $time);
    end
  always @(negedge clk)
    if (!rst && bv4) begin
      if (w4) begin
        wcnt++;
        wbin = b4;
      end
      if (e4) ecnt4++;
    end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end
  initial begin
    int seq4[6];
    int lat, pulses;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    gray_in = '0;
    in_valid = 1'b0;
    err_clr = 1'b0;
    cpipe = '0;
    g4 = '0;
    v4 = 1'b0;
    c4 = 1'b0;
    wbin = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin_out", bin_out, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_step_err", step_err, 0);
    @(negedge clk);
    rst = 1'b0;
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(3, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(3, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(4, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(5, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(9, 1, 0, 0, 1, 3, 1));
    tbl.push_back(mk(10, 1, 0, 0, 0, 3, 1));
    tbl.push_back(mk(20, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(21, 1, 0, 0, 0, 2, 1));
    tbl.push_back(mk(7, 1, 0, 0, 1, 3, 2));
    tbl.push_back(mk(8, 1, 0, 0, 0, 3, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(50, 1, 0, 0, 1, 3, 3));
    tbl.push_back(mk(51, 1, 1, 0, 0, 1, 3));
    tbl.push_back(mk(51, 1, 0, 0, 0, 2, 3));
    tbl.push_back(mk(52, 1, 1, 0, 0, 2, 3));
    tbl.push_back(mk(60, 1, 0, 0, 1, 3, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(61, 1, 0, 0, 0, 3, 4));
    tbl.push_back(mk(131071, 1, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 1, 0, 2, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 4));
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
    idle(LAT + 2);
    chk("table_drained", sb.size(), 0);
    do_reset();
    wcnt = 0;
    ecnt4 = 0;
    seq4 = '{13, 14, 15, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      g4 = 4'(seq4[k]) ^ (4'(seq4[k]) >> 1);
      v4 = 1'b1;
    end
    @(posedge clk);
    #1;
    v4 = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("wrap4_count", wcnt, 1);
    chk("wrap4_bin", wbin, 0);
    chk("wrap4_step_errs", ecnt4, 0);
    chk("wrap4_state", st4, 2);
    chk("wrap4_bin_final", b4, 1);
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      send(mk(0, 1, 1, 0, 0, 1, (k - 1 > 255) ? 255 : k - 1));
      send(mk(5, 1, 0, 0, 1, 3, (k > 255) ? 255 : k));
    end
    idle(LAT + 2);
    chk("err_cnt_saturated", err_cnt, 255);
    chk("sat_drained", sb.size(), 0);
    do_reset();
    send(mk(0, 1, 0, 0, 0, 1, 0));
    send(mk(9, 1, 0, 0, 1, 3, 1));
    send(mk(10, 1, 0, 0, 0, 3, 1));
    send(mk(11, 1, 0, 0, 0, 3, 1));
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    err_clr = 1'b0;
    cpipe = '0;
    #1;
    chk("async_rst_bin_valid", bin_valid, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_bin_out", bin_out, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bin_valid) pulses++;
    end
    chk("no_valid_after_rst", pulses, 0);
    chk("idle_after_rst", state, 0);
    send(mk(7, 1, 0, 0, 0, 1, 0));
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      if (bin_valid) break;
    end
    chk("latency", lat, LAT);
    idle(LAT + 2);
    chk("final_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
